nrd_control_unit: RTL and testbench

- Moore-style sequencer for the 8-bit non-restoring divider datapath. It sits directly upstream of the 16x8 register bank and drives its write-mux select, write address, write enable, read-mux select and constant bus.
- It also drives the ALU opcode and carry-in, and consumes the ALU sign and shift-out flags.
- It computes Q = InA / InB and R = InA % InB, unsigned, leaving Q in R3 and R in R7.

---
 rtl/nrd_pkg.sv | 56 +++++
 rtl/nrd_ctrl_decode.sv | 110 +++++++++++
 rtl/nrd_control_unit.sv | 139 +++++++++++++
 tb/tb_nrd_control_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/nrd_pkg.sv
// Shared encodings for the non-restoring divider sequencer.
// The NRD_DIVZERO_EN macro (used in nrd_control_unit) enables the divide-by-zero short path.
package nrd_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned REG_AW   = 4;
    localparam int unsigned MUX_W    = 3;
    localparam int unsigned ALU_OP_W = 3;

    // Bank write-source select codes
    localparam logic [MUX_W-1:0] MUX_INA   = 3'd0;
    localparam logic [MUX_W-1:0] MUX_INB   = 3'd1;
    localparam logic [MUX_W-1:0] MUX_CONST = 3'd2;
    localparam logic [MUX_W-1:0] MUX_ALU   = 3'd3;
    localparam logic [MUX_W-1:0] MUX_REG   = 3'd4;

    // ALU opcodes
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SHL  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'd4;

    // Fixed register roles in the bank
    localparam logic [REG_AW-1:0] R_ALUA = 4'd1;
    localparam logic [REG_AW-1:0] R_ALUB = 4'd2;
    localparam logic [REG_AW-1:0] R_Q    = 4'd3;
    localparam logic [REG_AW-1:0] R_M    = 4'd4;
    localparam logic [REG_AW-1:0] R_A    = 4'd7;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_LD_M,
        ST_LD_Q,
        ST_LD_QZ,
        ST_LD_A,
        ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6,
        ST_S7, ST_S8, ST_S9, ST_S10, ST_S11,
        ST_FIX,
        ST_F1, ST_F2, ST_F3,
        ST_Z_A,
        ST_Z_Q,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [MUX_W-1:0]    in_mux;
        logic [REG_AW-1:0]   reg_add;
        logic                we;
        logic [REG_AW-1:0]   out_mux;
        logic [DATA_W-1:0]   cu_const;
        logic [ALU_OP_W-1:0] alu_sel;
        logic                alu_cin;
    } ctrl_t;

endpackage

// File: rtl/nrd_ctrl_decode.sv
// Combinational per-state decode of the register-bank and ALU control word.
module nrd_ctrl_decode
    import nrd_pkg::*;
(
    input  state_t state,
    input  logic   cq,
    input  logic   sgn,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_LD_M: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_M;
                ctrl.in_mux  = MUX_INB;
            end
            ST_LD_Q, ST_LD_QZ: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_Q;
                ctrl.in_mux  = MUX_INA;
            end
            ST_LD_A: begin
                ctrl.we       = 1'b1;
                ctrl.reg_add  = R_A;
                ctrl.in_mux   = MUX_CONST;
                ctrl.cu_const = 8'h00;
            end
            ST_S1: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_ALUA;
                ctrl.in_mux  = MUX_REG;
                ctrl.out_mux = R_Q;
            end
            ST_S2: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_Q;
                ctrl.in_mux  = MUX_ALU;
                ctrl.alu_sel = ALU_SHL;
                ctrl.alu_cin = 1'b0;
            end
            ST_S3, ST_S5, ST_F1: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_ALUA;
                ctrl.in_mux  = MUX_REG;
                ctrl.out_mux = R_A;
            end
            // Dividend MSB captured in S2 shifts into the partial remainder
            ST_S4: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_A;
                ctrl.in_mux  = MUX_ALU;
                ctrl.alu_sel = ALU_SHL;
                ctrl.alu_cin = cq;
            end
            ST_S6, ST_F2: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_ALUB;
                ctrl.in_mux  = MUX_REG;
                ctrl.out_mux = R_M;
            end
            ST_S7: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_A;
                ctrl.in_mux  = MUX_ALU;
                ctrl.alu_sel = sgn ? ALU_ADD : ALU_SUB;
            end
            ST_S8: begin
                if (!sgn) begin
                    ctrl.we      = 1'b1;
                    ctrl.reg_add = R_ALUA;
                    ctrl.in_mux  = MUX_REG;
                    ctrl.out_mux = R_Q;
                end
            end
            ST_S9: begin
                ctrl.we       = 1'b1;
                ctrl.reg_add  = R_ALUB;
                ctrl.in_mux   = MUX_CONST;
                ctrl.cu_const = 8'h01;
            end
            ST_S10: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_Q;
                ctrl.in_mux  = MUX_ALU;
                ctrl.alu_sel = ALU_OR;
            end
            ST_F3: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_A;
                ctrl.in_mux  = MUX_ALU;
                ctrl.alu_sel = ALU_ADD;
            end
            ST_Z_A: begin
                ctrl.we      = 1'b1;
                ctrl.reg_add = R_A;
                ctrl.in_mux  = MUX_INA;
            end
            ST_Z_Q: begin
                ctrl.we       = 1'b1;
                ctrl.reg_add  = R_Q;
                ctrl.in_mux   = MUX_CONST;
                ctrl.cu_const = 8'hFF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nrd_control_unit.sv
// Moore sequencer driving the register bank and ALU through an 8-bit non-restoring division.
// Define NRD_DIVZERO_EN to add the divide-by-zero short path and the err flag.
module nrd_control_unit
    import nrd_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] InB,
    input  logic       ALUn,
    input  logic       ALUc,
    output logic [2:0] InMuxAdd,
    output logic [3:0] RegAdd,
    output logic       WE,
    output logic [3:0] OutMuxAdd,
    output logic [7:0] CUconst,
    output logic [2:0] ALUsel,
    output logic       ALUcin,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

`ifdef NRD_DIVZERO_EN
    localparam logic DIVZ_EN = 1'b1;
`else
    localparam logic DIVZ_EN = 1'b0;
`endif

    state_t        state;
    state_t        nxt_state;
    logic [CW-1:0] cnt;
    logic          cq;
    logic          sgn;
    logic          inb_zero_c;
    ctrl_t         ctrl;

    assign inb_zero_c = DIVZ_EN && (InB == 8'h00);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt_state;
    end

    // Next-state logic
    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE:  if (start) nxt_state = ST_LD_M;
            ST_LD_M:  nxt_state = inb_zero_c ? ST_LD_QZ : ST_LD_Q;
            ST_LD_Q:  nxt_state = ST_LD_A;
            ST_LD_QZ: nxt_state = ST_Z_A;
            ST_LD_A:  nxt_state = ST_S1;
            ST_S1:    nxt_state = ST_S2;
            ST_S2:    nxt_state = ST_S3;
            ST_S3:    nxt_state = ST_S4;
            ST_S4:    nxt_state = ST_S5;
            ST_S5:    nxt_state = ST_S6;
            ST_S6:    nxt_state = ST_S7;
            ST_S7:    nxt_state = ST_S8;
            ST_S8:    nxt_state = sgn ? ST_S11 : ST_S9;
            ST_S9:    nxt_state = ST_S10;
            ST_S10:   nxt_state = ST_S11;
            ST_S11:   nxt_state = (cnt == CNT_LAST) ? ST_FIX : ST_S1;
            ST_FIX:   nxt_state = sgn ? ST_F1 : ST_DONE;
            ST_F1:    nxt_state = ST_F2;
            ST_F2:    nxt_state = ST_F3;
            ST_F3:    nxt_state = ST_DONE;
            ST_Z_A:   nxt_state = ST_Z_Q;
            ST_Z_Q:   nxt_state = ST_DONE;
            ST_DONE:  nxt_state = ST_IDLE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    // Iteration counter, shifted-out quotient bit and remainder sign
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            cq  <= 1'b0;
            sgn <= 1'b0;
        end else begin
            case (state)
                ST_LD_A: begin
                    cnt <= '0;
                    sgn <= 1'b0;
                end
                ST_S2:   cq  <= ALUc;
                ST_S7:   sgn <= ALUn;
                ST_S11:  cnt <= cnt + CW'(1);
                default: ;
            endcase
        end
    end

`ifdef NRD_DIVZERO_EN
    // Sticky until the next accepted start
    always_ff @(posedge clk) begin
        if (rst)                             err <= 1'b0;
        else if (state == ST_IDLE && start)  err <= 1'b0;
        else if (state == ST_Z_Q)            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    nrd_ctrl_decode u_decode (
        .state (state),
        .cq    (cq),
        .sgn   (sgn),
        .ctrl  (ctrl)
    );

    // Output logic
    always_comb begin
        InMuxAdd  = ctrl.in_mux;
        RegAdd    = ctrl.reg_add;
        WE        = ctrl.we;
        OutMuxAdd = ctrl.out_mux;
        CUconst   = ctrl.cu_const;
        ALUsel    = ctrl.alu_sel;
        ALUcin    = ctrl.alu_cin;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_DONE: done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_nrd_control_unit.sv
// Closed-loop bench: a behavioural register bank and ALU around nrd_control_unit,
// results and latency compared against plain-arithmetic division.
module tb_nrd_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] InA;
    logic [7:0] InB;
    logic       ALUn;
    logic       ALUc;
    logic [2:0] InMuxAdd;
    logic [3:0] RegAdd;
    logic       WE;
    logic [3:0] OutMuxAdd;
    logic [7:0] CUconst;
    logic [2:0] ALUsel;
    logic       ALUcin;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

`ifdef NRD_DIVZERO_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    nrd_control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .InB       (InB),
        .ALUn      (ALUn),
        .ALUc      (ALUc),
        .InMuxAdd  (InMuxAdd),
        .RegAdd    (RegAdd),
        .WE        (WE),
        .OutMuxAdd (OutMuxAdd),
        .CUconst   (CUconst),
        .ALUsel    (ALUsel),
        .ALUcin    (ALUcin),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural 16x8 bank and ALU
    logic [7:0] bank [16];
    logic [7:0] reg_out;
    logic [7:0] alu_y;
    logic [7:0] wdata;

    always_comb begin
        reg_out = bank[OutMuxAdd];
        case (ALUsel)
            3'd0:    alu_y = bank[1];
            3'd1:    alu_y = bank[1] + bank[2];
            3'd2:    alu_y = bank[1] - bank[2];
            3'd3:    alu_y = {bank[1][6:0], ALUcin};
            3'd4:    alu_y = bank[1] | bank[2];
            default: alu_y = 8'h00;
        endcase
        case (InMuxAdd)
            3'd0:    wdata = InA;
            3'd1:    wdata = InB;
            3'd2:    wdata = CUconst;
            3'd3:    wdata = alu_y;
            3'd4:    wdata = reg_out;
            default: wdata = 8'h00;
        endcase
    end

    assign ALUn = alu_y[7];
    assign ALUc = bank[1][7];

    always @(posedge clk) if (WE) bank[RegAdd] <= wdata;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference latency: edges from the start edge to DONE, from signed-integer non-restoring steps
    function automatic int ref_latency(input int a, input int b);
        int acc  = 0;
        bit neg  = 1'b0;
        int negs = 0;
        for (int i = 7; i >= 0; i--) begin
            acc = 2 * acc + ((a >> i) & 1);
            acc = neg ? acc + b : acc - b;
            neg = (acc < 0);
            if (neg) negs++;
        end
        return 4 + 11 * (8 - negs) + 9 * negs + (neg ? 3 : 0);
    endfunction

    task automatic run_div(input int a, input int b, input string tag, input int ign_s4);
        int lat     = 0;
        int s4_seen = 0;
        bit busy_ok = 1'b1;
        int exp_q, exp_r, exp_lat;
        @(negedge clk);
        InA   = 8'(a);
        InB   = 8'(b);
        start = 1'b1;
        @(negedge clk);
        while (!done && lat < 400) begin
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (ign_s4 > 0 && WE && RegAdd == 4'd7 && ALUsel == 3'd3) begin
                s4_seen++;
                if (s4_seen == ign_s4) start = 1'b1;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_busy_run"}, int'(busy_ok), 1);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        check({tag, "_err"}, int'(err), (DZ && b == 0) ? 1 : 0);
        if (b != 0) begin
            exp_q   = a / b;
            exp_r   = a % b;
            exp_lat = ref_latency(a, b);
            check({tag, "_q"}, int'(bank[3]), exp_q);
            check({tag, "_r"}, int'(bank[7]), exp_r);
            check({tag, "_lat"}, lat, exp_lat);
        end else if (DZ) begin
            check({tag, "_q"}, int'(bank[3]), 255);
            check({tag, "_r"}, int'(bank[7]), a);
            check({tag, "_lat"}, lat, 4);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
    endtask

    function automatic int out_vec();
        return int'({InMuxAdd, RegAdd, WE, OutMuxAdd, CUconst, ALUsel, ALUcin, busy, done, err});
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit found;
        int a, b;
        for (int i = 0; i < 16; i++) bank[i] = 8'h00;
        rst   = 1'b1;
        start = 1'b0;
        InA   = 8'h00;
        InB   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", out_vec(), 0);
        rst = 1'b0;

        run_div(100, 7, "d100_7", 0);
        run_div(255, 1, "d255_1", 0);
        run_div(5, 9, "d5_9", 0);
        run_div(200, 0, "d200_0", 0);
        repeat (3) @(negedge clk);
        check("err_sticky", int'(err), DZ ? 1 : 0);
        run_div(100, 7, "ign_start", 3);

        // Reset in the middle of the first S7
        @(negedge clk);
        InA   = 8'd100;
        InB   = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (WE && RegAdd == 4'd7 && (ALUsel == 3'd2 || ALUsel == 3'd1)) found = 1'b1;
            else @(negedge clk);
        end
        check("s7_reached", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_reset_outputs", out_vec(), 0);
        rst = 1'b0;
        run_div(100, 7, "after_rst", 0);

        for (int t = 0; t < 20; t++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 64));
            run_div(a, b, "rand", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
